wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DW, 32, datapath width in bits.
REQ-002 Parameter AW, 5, register-address width in bits.
REQ-003 Parameter NREGS, 32, number of architectural registers; register 0 reads as zero and is never written.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clrn  input  1  reset; asynchronous, active-low.
REQ-006 mvalid  input  1  MEM stage presents a valid instruction this cycle.
REQ-007 mwreg  input  1  instruction writes the register file.
REQ-008 mm2reg  input  1  write data comes from memory (1) or from the ALU (0).
REQ-009 mrn  input  AW  destination register number (the Rd/Rt selection made in ID).
REQ-010 malu  input  DW  ALU result.
REQ-011 mmo  input  DW  memory read data.
REQ-012 wb_ready  output  1  stage accepts MEM-stage input this cycle.
REQ-013 wreg  output  1  register-file write enable (drives the ID write port).
REQ-014 wn  output  AW  register-file write address.
REQ-015 wdata  output  DW  register-file write data.
REQ-016 init_done  output  1  register-file clear sequence complete.
REQ-017 retired  output  32  count of accepted instructions.

Function
REQ-018 The FSM SHALL have two states: INIT (clear register file) and RUN (normal writeback).
REQ-019 In INIT, an index counter SHALL start at 1, and each rising edge SHALL load wreg=1, wn=index, wdata=0, then increment the index.
REQ-020 The edge that loads index NREGS-1 (31) SHALL also move the FSM to RUN; INIT lasts exactly NREGS-1 cycles.
REQ-021 wb_ready and init_done SHALL be 1 iff state==RUN, decoded combinationally from the state register.
REQ-022 In INIT, mvalid and all M-side inputs SHALL be ignored; upstream SHALL NOT present instructions while wb_ready=0.
REQ-023 In RUN, an instruction is accepted on an edge where mvalid=1.
REQ-024 On acceptance, the outputs SHALL load on the same edge, giving 1-cycle latency: wreg = mwreg AND (mrn != 0); wn = mrn; wdata = mm2reg ? mmo : malu.
REQ-025 In RUN, an edge with mvalid=0 SHALL load wreg=0 (bubble) and hold wn and wdata.
REQ-026 A write to register 0 SHALL be suppressed (wreg=0), while wn and wdata still load.
REQ-027 retired SHALL increment by 1 on every accepted instruction, including mwreg=0 and mrn=0 cases, and wrap from 2^32-1 to 0.
REQ-028 retired SHALL NOT count INIT writes.
REQ-029 All outputs except wb_ready and init_done SHALL be registered.

Reset
REQ-030 When clrn=0, the block SHALL immediately force state=INIT, index=1, wreg=0, wn=0, wdata=0, retired=0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity; the clear sequence SHALL restart from index 1 on the first rising edge after clrn deasserts.

Structure
REQ-032 A shared package SHALL hold DW, AW, NREGS and the state enumeration {INIT, RUN}.
REQ-033 One sub-module, wb_mux (the combinational mm2reg data select plus the register-0 write suppression), SHALL be instantiated; all other logic stays in wb_stage.

Verification
REQ-034 Reset release -> wreg=1 with wn=1..31 on consecutive cycles, wdata=0 throughout; init_done=1 from cycle 31; wb_ready=0 before that.
REQ-035 RUN, mvalid=1, mwreg=1, mm2reg=0, mrn=8, malu=0x0000_1234 -> next cycle wreg=1, wn=8, wdata=0x0000_1234; retired=1.
REQ-036 RUN, mvalid=1, mwreg=1, mm2reg=1, mrn=9, mmo=0xDEAD_BEEF, malu=0x5 -> wdata=0xDEAD_BEEF; then mvalid=0 -> wreg=0, wn=9 held.
REQ-037 RUN, mvalid=1, mwreg=1, mrn=0 -> wreg=0; retired increments.
REQ-038 clrn pulsed low at INIT index 17 -> outputs cleared asynchronously; after release the sequence restarts at wn=1.
REQ-039 retired preloaded to 0xFFFF_FFFF by a run of 2^32-1 accepts (or a forced value in simulation), then one more accept -> retired=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared widths and FSM state encoding for the writeback stage.
package wb_stage_pkg;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_t;
endpackage

// File: rtl/wb_mux.sv
// Writeback data select plus register-0 write suppression (combinational).
module wb_mux #(
    parameter int DW = wb_stage_pkg::DW,
    parameter int AW = wb_stage_pkg::AW
) (
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [AW-1:0] mrn,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mmo,
    output logic          we,
    output logic [DW-1:0] data
);
    assign we   = mwreg && (mrn != '0);
    assign data = mm2reg ? mmo : malu;
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: clears the register file after reset, then registers
// MEM-stage results onto the register-file write port and counts retirements.
module wb_stage #(
    parameter int DW    = wb_stage_pkg::DW,
    parameter int AW    = wb_stage_pkg::AW,
    parameter int NREGS = wb_stage_pkg::NREGS
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mvalid,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [AW-1:0] mrn,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mmo,
    output logic          wb_ready,
    output logic          wreg,
    output logic [AW-1:0] wn,
    output logic [DW-1:0] wdata,
    output logic          init_done,
    output logic [31:0]   retired
);
    import wb_stage_pkg::*;

    wb_state_t     state;
    logic [AW-1:0] index;
    logic          mux_we;
    logic [DW-1:0] mux_data;

    wb_mux #(.DW(DW), .AW(AW)) u_mux (
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .malu   (malu),
        .mmo    (mmo),
        .we     (mux_we),
        .data   (mux_data)
    );

    assign wb_ready  = (state == RUN);
    assign init_done = (state == RUN);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= INIT;
            index   <= AW'(1);
            wreg    <= 1'b0;
            wn      <= '0;
            wdata   <= '0;
            retired <= '0;
        end else begin
            case (state)
                INIT: begin
                    // Register 0 is hardwired, so the sweep covers 1..NREGS-1.
                    wreg  <= 1'b1;
                    wn    <= index;
                    wdata <= '0;
                    index <= index + AW'(1);
                    if (index == AW'(NREGS - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (mvalid) begin
                        wreg    <= mux_we;
                        wn      <= mrn;
                        wdata   <= mux_data;
                        retired <= retired + 32'd1;
                    end else begin
                        wreg <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a spec-level model.
module tb_wb_stage;
    logic        clk;
    logic        clrn;
    logic        mvalid, mwreg, mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;
    logic        wb_ready, wreg, init_done;
    logic [4:0]  wn;
    logic [31:0] wdata, retired;

    int total = 0;
    int bad   = 0;

    logic        exp_wreg;
    logic [4:0]  exp_wn;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ret;

    wb_stage dut (
        .clk       (clk),
        .clrn      (clrn),
        .mvalid    (mvalid),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mrn       (mrn),
        .malu      (malu),
        .mmo       (mmo),
        .wb_ready  (wb_ready),
        .wreg      (wreg),
        .wn        (wn),
        .wdata     (wdata),
        .init_done (init_done),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_m();
        mvalid = 1'($urandom);
        mwreg  = 1'($urandom);
        mm2reg = 1'($urandom);
        mrn    = 5'($urandom);
        malu   = $urandom;
        mmo    = $urandom;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_wreg"}, 64'(wreg), 64'd0);
        chk({tag, "_wn"}, 64'(wn), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_ret"}, 64'(retired), 64'd0);
        chk({tag, "_ready"}, 64'(wb_ready), 64'd0);
    endtask

    // Walk n edges of the clear sweep; M-side inputs are noise and must be ignored.
    task automatic run_init(input int n);
        chk("init_ready0", 64'(wb_ready), 64'd0);
        for (int k = 1; k <= n; k++) begin
            rand_m();
            @(posedge clk); #1;
            chk("init_wreg", 64'(wreg), 64'd1);
            chk("init_wn", 64'(wn), 64'(k));
            chk("init_wdata", 64'(wdata), 64'd0);
            chk("init_ready", 64'(wb_ready), 64'(k >= 31));
            chk("init_done", 64'(init_done), 64'(k >= 31));
            chk("init_ret", 64'(retired), 64'd0);
        end
        exp_wreg  = 1'b1;
        exp_wn    = 5'(n);
        exp_wdata = '0;
        exp_ret   = '0;
    endtask

    task automatic step(input logic v, input logic w, input logic m2r,
                        input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] mo);
        mvalid = v; mwreg = w; mm2reg = m2r; mrn = rn; malu = alu; mmo = mo;
        @(posedge clk); #1;
        if (v) begin
            exp_wreg  = w && (rn != 0);
            exp_wn    = rn;
            exp_wdata = m2r ? mo : alu;
            exp_ret   = exp_ret + 1;
        end else begin
            exp_wreg = 1'b0;
        end
        chk("run_wreg", 64'(wreg), 64'(exp_wreg));
        chk("run_wn", 64'(wn), 64'(exp_wn));
        chk("run_wdata", 64'(wdata), 64'(exp_wdata));
        chk("run_ret", 64'(retired), 64'(exp_ret));
        chk("run_ready", 64'(wb_ready), 64'd1);
    endtask

    initial begin
        clrn = 1'b0;
        mvalid = 0; mwreg = 0; mm2reg = 0; mrn = 0; malu = 0; mmo = 0;
        #22;
        chk_cleared("rst");
        @(negedge clk); clrn = 1'b1;
        run_init(31);

        step(1, 1, 0, 5'd8, 32'h0000_1234, $urandom);
        chk("d1_wreg", 64'(wreg), 64'd1);
        chk("d1_wn", 64'(wn), 64'd8);
        chk("d1_wdata", 64'(wdata), 64'h1234);
        chk("d1_ret", 64'(retired), 64'd1);

        step(1, 1, 1, 5'd9, 32'h5, 32'hDEAD_BEEF);
        chk("d2_wdata", 64'(wdata), 64'hDEAD_BEEF);
        step(0, 1, 0, 5'd3, $urandom, $urandom);
        chk("d2_bubble_wreg", 64'(wreg), 64'd0);
        chk("d2_bubble_wn", 64'(wn), 64'd9);
        chk("d2_bubble_wdata", 64'(wdata), 64'hDEAD_BEEF);

        step(1, 1, 0, 5'd0, 32'hAAAA_5555, $urandom);
        chk("d3_r0_wreg", 64'(wreg), 64'd0);
        chk("d3_r0_ret", 64'(retired), 64'd3);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] rn;
            rn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step(1'($urandom), 1'($urandom), 1'($urandom), rn, $urandom, $urandom);
        end

        // Abort the clear sweep partway through, then confirm it restarts at 1.
        @(negedge clk); clrn = 1'b0;
        #1 chk_cleared("rst_run");
        @(negedge clk); clrn = 1'b1;
        run_init(17);
        #1 clrn = 1'b0;
        #1 chk_cleared("rst_mid");
        @(negedge clk); clrn = 1'b1;
        run_init(31);

        step(1, 0, 0, 5'd4, 32'h1, 32'h2);
        @(negedge clk);
        force dut.retired = 32'hFFFF_FFFF;
        #1 release dut.retired;
        chk("wrap_pre", 64'(retired), 64'hFFFF_FFFF);
        exp_ret = 32'hFFFF_FFFF;
        #1;
        step(1, 1, 1, 5'd12, $urandom, $urandom);
        chk("wrap_ret", 64'(retired), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
